// File: rtl/scroll_lines.sv
// -----------------------------------------------------------------------------
// scroll_lines
//   Generates four horizontally scrolling platform lines for the player stage.
//   Each line is a ScreenWidth-column bitmap (1 = solid, 0 = gap) where
//   bit[x] is screen column x.
//
//   A prescaler sets the scroll rate. On every scroll step each line shifts one
//   column towards x=0, and a new column enters at x=ScreenWidth-1. The new
//   column comes from a per-line SOLID/GAP run-length FSM. All four FSMs draw
//   their random run lengths from one shared 16-bit Fibonacci LFSR.
//
//   Only one line may be in GAP at any time. A line whose solid run ends while
//   another line is in GAP keeps drawing solid columns until the slot frees.
//   When several lines ask for the slot together, the lowest line index wins.
//
//   Optional feature (macro SCROLL_LINES_SPEEDUP_EN):
//     The divider becomes a register. Every 256 steps it shrinks by
//     ScrollDiv/64, and it never goes below ScrollDivMin. Without the macro
//     the divider is the constant ScrollDiv.
//
// Ports
//   clk_i          in   1            system clock
//   rst_i          in   1            asynchronous reset, active-low
//   run_i          in   1            1 = scroll, 0 = freeze all state
//   line0_o..3_o   out  ScreenWidth  line bitmaps
//   scroll_tick_o  out  1            one-cycle pulse in the cycle a step lands
//   distance_o     out  16           steps since reset, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module scroll_lines #(
    parameter int          ScreenWidth  = 640,
    parameter int          ScrollDiv    = 400000,
    parameter int          ScrollDivMin = 100000,
    parameter int          SegMinLen    = 96,
    parameter int          GapMinLen    = 24,
    parameter logic [15:0] Seed         = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   run_i,
    output logic [ScreenWidth-1:0] line0_o,
    output logic [ScreenWidth-1:0] line1_o,
    output logic [ScreenWidth-1:0] line2_o,
    output logic [ScreenWidth-1:0] line3_o,
    output logic                   scroll_tick_o,
    output logic [15:0]            distance_o
);

    typedef enum logic {
        ST_SOLID = 1'b0,
        ST_GAP   = 1'b1
    } line_state_e;

    // An all-zero LFSR would lock up, so a zero seed falls back to 16'hACE1.
    localparam logic [15:0] SeedEff = (Seed == 16'h0000) ? 16'hACE1 : Seed;
    localparam logic [9:0]  SegLen0 = 10'(SegMinLen);
    localparam logic [9:0]  GapLen0 = 10'(GapMinLen);
    localparam logic [31:0] DivInit = 32'(ScrollDiv);

    // Fibonacci LFSR with taps 16,14,13,11. It shifts towards bit 0, and the
    // feedback bit enters at bit 15.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    logic [31:0]            r_presc;
    logic [15:0]            r_lfsr;
    logic [15:0]            r_dist;
    logic                   r_tick;
    line_state_e            r_state    [4];
    logic [9:0]             r_cnt      [4];
    logic [ScreenWidth-1:0] r_line     [4];

    logic [31:0]            w_div;
    logic                   w_step;
    logic                   w_slot_taken;
    logic [3:0]             w_r;
    line_state_e            w_state_nxt [4];
    logic [9:0]             w_cnt_nxt   [4];
    logic [ScreenWidth-1:0] w_line_nxt  [4];

`ifdef SCROLL_LINES_SPEEDUP_EN
    localparam logic [31:0] DivStep = 32'(ScrollDiv / 64);
    localparam logic [31:0] DivMin  = 32'(ScrollDivMin);

    logic [31:0] r_div;

    // The divider shrinks each time the low byte of distance rolls over to 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div <= DivInit;
        end else if (w_step && (r_dist != 16'hFFFF) && (r_dist[7:0] == 8'hFF)) begin
            r_div <= (r_div >= (DivMin + DivStep)) ? (r_div - DivStep) : DivMin;
        end else begin
            r_div <= r_div;
        end
    end

    assign w_div = r_div;
`else
    assign w_div = DivInit;
`endif

    // ">=" rather than "==" lets a freshly shrunk divider wrap on the next clock.
    assign w_step = run_i && (r_presc >= (w_div - 32'd1));

    // Prescaler, LFSR, distance counter and tick pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_presc <= 32'd0;
            r_lfsr  <= SeedEff;
            r_dist  <= 16'd0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_step;
            if (w_step) begin
                r_presc <= 32'd0;
                r_lfsr  <= lfsr_next(r_lfsr);
                r_dist  <= (r_dist == 16'hFFFF) ? r_dist : (r_dist + 16'd1);
            end else if (run_i) begin
                r_presc <= r_presc + 32'd1;
            end else begin
                r_presc <= r_presc;
            end
        end
    end

    // Next-state logic for the four lines, including the gap-slot arbitration.
    always_comb begin
        // The slot is judged on current states only. A line that leaves GAP in
        // this step frees the slot for the next step, not for this one.
        w_slot_taken = (r_state[0] == ST_GAP) || (r_state[1] == ST_GAP) ||
                       (r_state[2] == ST_GAP) || (r_state[3] == ST_GAP);
        w_r = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_line_nxt[i]  = r_line[i];
            w_r            = r_lfsr[4*i +: 4];
            if (w_step) begin
                w_line_nxt[i] = {(r_state[i] == ST_SOLID), r_line[i][ScreenWidth-1:1]};
                if (r_cnt[i] > 10'd1) begin
                    w_cnt_nxt[i] = r_cnt[i] - 10'd1;
                end else begin
                    case (r_state[i])
                        ST_SOLID: begin
                            if (!w_slot_taken) begin
                                w_state_nxt[i] = ST_GAP;
                                w_cnt_nxt[i]   = GapLen0 + {6'd0, w_r};
                                w_slot_taken   = 1'b1;
                            end else begin
                                // Deferred: the solid run grows by one column per step.
                                w_cnt_nxt[i] = 10'd1;
                            end
                        end
                        ST_GAP: begin
                            w_state_nxt[i] = ST_SOLID;
                            w_cnt_nxt[i]   = SegLen0 + {4'd0, w_r, 2'b00};
                        end
                        default: begin
                            w_state_nxt[i] = ST_SOLID;
                            w_cnt_nxt[i]   = SegLen0;
                        end
                    endcase
                end
            end else begin
                w_line_nxt[i] = r_line[i];
            end
        end
    end

    // State registers for the lines. Reset staggers each line's first gap by 32 steps.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= ST_SOLID;
                r_cnt[i]   <= SegLen0 + 10'(32 * i);
                r_line[i]  <= {ScreenWidth{1'b1}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_line[i]  <= w_line_nxt[i];
            end
        end
    end

    assign line0_o       = r_line[0];
    assign line1_o       = r_line[1];
    assign line2_o       = r_line[2];
    assign line3_o       = r_line[3];
    assign scroll_tick_o = r_tick;
    assign distance_o    = r_dist;

endmodule

// File: tb/tb_scroll_lines.sv
// -----------------------------------------------------------------------------
// tb_scroll_lines
//   Directed bench for scroll_lines with ScrollDiv=4 and Seed=16'hACE1.
//   Covers: reset state, tick rate, first gap on line 0, run_i hold,
//   asynchronous reset in the middle of a run, and run-length and gap
//   exclusivity properties over a long run.
// -----------------------------------------------------------------------------
module tb_scroll_lines;

    localparam int W = 640;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         run_i = 1'b0;
    logic [W-1:0] line0_o, line1_o, line2_o, line3_o;
    logic         scroll_tick_o;
    logic [15:0]  distance_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [4*W-1:0] all_ones = {4*W{1'b1}};

    scroll_lines #(
        .ScreenWidth (W),
        .ScrollDiv   (4),
        .ScrollDivMin(2),
        .SegMinLen   (96),
        .GapMinLen   (24),
        .Seed        (16'hACE1)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .run_i        (run_i),
        .line0_o      (line0_o),
        .line1_o      (line1_o),
        .line2_o      (line2_o),
        .line3_o      (line3_o),
        .scroll_tick_o(scroll_tick_o),
        .distance_o   (distance_o)
    );

    always #5 clk_i = ~clk_i;

    // Waits on falling edges for a tick, giving up after max_cyc cycles.
    task automatic wait_tick(input int max_cyc, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        while (!got && (cyc < max_cyc)) begin
            @(negedge clk_i);
            cyc++;
            if (scroll_tick_o === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        @(negedge clk_i);
        total_cnt++;
        if ({line0_o, line1_o, line2_o, line3_o} !== all_ones)
            $display("FAIL reset_lines: got a line bit at 0, required all ones");
        else pass_cnt++;
        total_cnt++;
        if (scroll_tick_o !== 1'b0) $display("FAIL reset_tick: got %b required 0", scroll_tick_o);
        else pass_cnt++;
        total_cnt++;
        if (distance_o !== 16'd0) $display("FAIL reset_distance: got %0d required 0", distance_o);
        else pass_cnt++;
    endtask

    task automatic test_tick_rate;
        int cyc;
        bit got;
        rst_i = 1'b1;
        run_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_tick(20, cyc, got);
            total_cnt++;
            if (!got || cyc != 4) $display("FAIL tick_period: got %0d cycles (seen=%0b) required 4", cyc, got);
            else pass_cnt++;
            total_cnt++;
            if (distance_o !== 16'(k)) $display("FAIL tick_distance: got %0d required %0d", distance_o, k);
            else pass_cnt++;
        end
        total_cnt++;
        if ({line0_o, line1_o, line2_o, line3_o} !== all_ones)
            $display("FAIL early_lines: got a line bit at 0 before step 96, required all ones");
        else pass_cnt++;
    endtask

    task automatic test_first_gap;
        int cyc;
        int gap_len;
        int guard;
        bit got;
        logic [15:0]  l;
        logic [W-1:0] prev;
        int exp_gap;
        // The gap length comes from the LFSR value before the 96th advance.
        l = 16'hACE1;
        for (int k = 0; k < 95; k++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        exp_gap = 24 + int'(l[3:0]);
        guard = 0;
        got = 1'b1;
        while (distance_o != 16'd96 && guard < 200 && got) begin
            wait_tick(20, cyc, got);
            guard++;
        end
        total_cnt++;
        if (distance_o !== 16'd96) $display("FAIL reach_step96: got %0d required 96", distance_o);
        else pass_cnt++;
        total_cnt++;
        if ({line0_o, line1_o, line2_o, line3_o} !== all_ones)
            $display("FAIL step96_lines: got a line bit at 0, required all ones");
        else pass_cnt++;
        prev = line0_o;
        wait_tick(20, cyc, got);
        total_cnt++;
        if (!got || line0_o[639] !== 1'b0)
            $display("FAIL step97_gap: got line0[639]=%b (seen=%0b) required 0", line0_o[639], got);
        else pass_cnt++;
        total_cnt++;
        if (line0_o[638:0] !== prev[639:1]) $display("FAIL shift: got %h required %h", line0_o[638:0], prev[639:1]);
        else pass_cnt++;
        gap_len = 1;
        guard = 0;
        got = 1'b1;
        while (line0_o[639] == 1'b0 && guard < 60 && got) begin
            wait_tick(20, cyc, got);
            if (line0_o[639] == 1'b0) gap_len++;
            guard++;
        end
        total_cnt++;
        if (gap_len != exp_gap) $display("FAIL first_gap_len: got %0d required %0d", gap_len, exp_gap);
        else pass_cnt++;
    endtask

    task automatic test_run_hold;
        int cyc;
        bit got;
        bit tick_seen;
        logic [15:0] d0;
        wait_tick(20, cyc, got);
        d0 = distance_o;
        @(negedge clk_i);
        run_i = 1'b0;
        tick_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (scroll_tick_o !== 1'b0) tick_seen = 1'b1;
        end
        total_cnt++;
        if (tick_seen || distance_o !== d0)
            $display("FAIL hold_no_tick: got tick=%0b distance=%0d required tick=0 distance=%0d", tick_seen, distance_o, d0);
        else pass_cnt++;
        run_i = 1'b1;
        wait_tick(20, cyc, got);
        total_cnt++;
        if (!got || cyc != 3) $display("FAIL hold_resume: got %0d cycles (seen=%0b) required 3", cyc, got);
        else pass_cnt++;
        total_cnt++;
        if (distance_o !== d0 + 16'd1) $display("FAIL hold_distance: got %0d required %0d", distance_o, d0 + 16'd1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_step;
        int cyc;
        int guard;
        bit got;
        guard = 0;
        got = 1'b1;
        while (distance_o != 16'd150 && guard < 200 && got) begin
            wait_tick(20, cyc, got);
            guard++;
        end
        total_cnt++;
        if (distance_o !== 16'd150 || scroll_tick_o !== 1'b1)
            $display("FAIL reach_step150: got %0d tick=%b required 150 tick=1", distance_o, scroll_tick_o);
        else pass_cnt++;
        rst_i = 1'b0;
        #1;
        total_cnt++;
        if ({line0_o, line1_o, line2_o, line3_o} !== all_ones || scroll_tick_o !== 1'b0 || distance_o !== 16'd0)
            $display("FAIL async_reset: got tick=%b distance=%0d required lines all ones, tick 0, distance 0", scroll_tick_o, distance_o);
        else pass_cnt++;
        @(posedge clk_i);
        #1;
        total_cnt++;
        if (distance_o !== 16'd0) $display("FAIL reset_hold_distance: got %0d required 0", distance_o);
        else pass_cnt++;
        @(negedge clk_i);
        rst_i = 1'b1;
        wait_tick(20, cyc, got);
        total_cnt++;
        if (!got || cyc != 4 || distance_o !== 16'd1)
            $display("FAIL post_reset_tick: got %0d cycles distance=%0d required 4 cycles distance 1", cyc, distance_o);
        else pass_cnt++;
    endtask

    task automatic test_gap_properties;
        int  cyc;
        bit  got;
        bit  timed_out;
        int  zeros;
        int  excl_bad;
        int  run_len [4];
        bit  cur     [4];
        int  gaps    [4];
        bit  b;
        // Starts right after the first tick following a reset.
        for (int i = 0; i < 4; i++) begin
            run_len[i] = 1;
            cur[i]     = 1'b1;
            gaps[i]    = 0;
        end
        excl_bad  = 0;
        timed_out = 1'b0;
        for (int s = 0; s < 4000 && !timed_out; s++) begin
            wait_tick(20, cyc, got);
            if (!got) timed_out = 1'b1;
            zeros = 0;
            if (!line0_o[639]) zeros++;
            if (!line1_o[639]) zeros++;
            if (!line2_o[639]) zeros++;
            if (!line3_o[639]) zeros++;
            if (zeros > 1) excl_bad++;
            for (int i = 0; i < 4; i++) begin
                case (i)
                    0: b = line0_o[639];
                    1: b = line1_o[639];
                    2: b = line2_o[639];
                    default: b = line3_o[639];
                endcase
                if (b == cur[i]) begin
                    run_len[i]++;
                end else begin
                    total_cnt++;
                    if (cur[i]) begin
                        if (run_len[i] < 96) $display("FAIL solid_run: line %0d got %0d required >=96", i, run_len[i]);
                        else pass_cnt++;
                    end else begin
                        gaps[i]++;
                        if (run_len[i] < 24 || run_len[i] > 39)
                            $display("FAIL gap_run: line %0d got %0d required 24..39", i, run_len[i]);
                        else pass_cnt++;
                    end
                    cur[i]     = b;
                    run_len[i] = 1;
                end
            end
        end
        total_cnt++;
        if (timed_out) $display("FAIL long_run_timeout: got no tick within 20 cycles, required one");
        else pass_cnt++;
        total_cnt++;
        if (excl_bad != 0) $display("FAIL gap_exclusive: got %0d steps with >1 gap required 0", excl_bad);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (gaps[i] < 5) $display("FAIL gap_count: line %0d got %0d gaps required >=5", i, gaps[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_tick_rate();
        test_first_gap();
        test_run_hold();
        test_reset_mid_step();
        test_gap_properties();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
